// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between memory and decode.
// Ports: clk/rst_n; redirect_i/redirect_addr_i restart fetch;
//   hold_i suppresses reads; mem_re_o/mem_addr_o/mem_data_i/mem_wait_i
//   talk to memory; instr_valid_o/instr_o/instr_pc_o/instr_ready_i feed
//   decode; count_o reports occupancy.
module fetch_queue #(
    parameter int                       PC_W       = 16,
    parameter int                       BANK_W     = 8,
    parameter int                       DATA_W     = 16,
    parameter int                       DEPTH      = 4,
    parameter logic [BANK_W+PC_W-1:0]   RESET_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_i,
    input  logic [BANK_W+PC_W-1:0]      redirect_addr_i,
    input  logic                        hold_i,
    output logic                        mem_re_o,
    output logic [BANK_W+PC_W-1:0]      mem_addr_o,
    input  logic [DATA_W-1:0]           mem_data_i,
    input  logic                        mem_wait_i,
    output logic                        instr_valid_o,
    output logic [DATA_W-1:0]           instr_o,
    output logic [BANK_W+PC_W-1:0]      instr_pc_o,
    input  logic                        instr_ready_i,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int ADDR_W = BANK_W + PC_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] EVEN_M  = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RST_A   = RESET_ADDR & EVEN_M;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [ADDR_W-1:0]   faddr_q, faddr_d;

    logic [DATA_W-1:0]   dat_q [DEPTH];
    logic [ADDR_W-1:0]   pc_q  [DEPTH];

    logic                push;
    logic                pop;

    // Gated by rst_n so no request is visible while reset is held.
    assign mem_re_o = rst_n & (state_q == FETCH) & ~hold_i
                    & ~redirect_i & (count_q < DEPTH_C);
    assign mem_addr_o    = faddr_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = dat_q[head_q];
    assign instr_pc_o    = pc_q[head_q];
    assign count_o       = count_q;

    always_comb begin
        push    = mem_re_o & ~mem_wait_i;
        pop     = instr_valid_o & instr_ready_i & ~redirect_i;
        state_d = state_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        faddr_d = faddr_q;
        if (redirect_i) begin
            // Redirect wins over any same-cycle push or pop.
            state_d = FETCH;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            faddr_d = redirect_addr_i & EVEN_M;
        end else begin
            if (push) begin
                tail_d  = tail_q + PTR_W'(1);
                // pc wraps inside the current bank.
                faddr_d = {faddr_q[ADDR_W-1:PC_W],
                           faddr_q[PC_W-1:0] + PC_W'(2)};
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            unique case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   state_d = (count_d == DEPTH_C) ? FULL : FETCH;
                FULL:    state_d = (count_d < DEPTH_C) ? FETCH : FULL;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            faddr_q <= RST_A;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            faddr_q <= faddr_d;
        end
    end

    // Payload storage carries no reset; validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            dat_q[tail_q] <= mem_data_i;
            pc_q[tail_q]  <= faddr_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus reset corner sequence
// for fetch_queue with default parameters.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [23:0] redirect_addr_i;
    logic        hold_i;
    logic        mem_re_o;
    logic [23:0] mem_addr_o;
    logic [15:0] mem_data_i;
    logic        mem_wait_i;
    logic        instr_valid_o;
    logic [15:0] instr_o;
    logic [23:0] instr_pc_o;
    logic        instr_ready_i;
    logic [2:0]  count_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .hold_i          (hold_i),
        .mem_re_o        (mem_re_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_i      (mem_data_i),
        .mem_wait_i      (mem_wait_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i),
        .count_o         (count_o)
    );

    // Memory content is a fixed function of address.
    function automatic logic [15:0] fdata(input logic [23:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3C3 ^ {8'h00, a[23:16]};
    endfunction

    assign mem_data_i = fdata(mem_addr_o);

    typedef struct {
        logic        rd;
        logic [23:0] ra;
        logic        hold;
        logic        wt;
        logic        rdy;
        logic        re;
        logic [23:0] addr;
        logic        v;
        logic [23:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl [36];

    function automatic vec_t mk(
        input logic rd, input logic [23:0] ra, input logic hold,
        input logic wt, input logic rdy, input logic re,
        input logic [23:0] addr, input logic v,
        input logic [23:0] pc, input logic [2:0] cnt);
        vec_t r;
        r.rd = rd; r.ra = ra; r.hold = hold; r.wt = wt; r.rdy = rdy;
        r.re = re; r.addr = addr; r.v = v; r.pc = pc; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s step %0d: got %0h expected %0h",
                     nm, idx, act, exp);
        end
    endtask

    task automatic chk_vec(input int idx, input vec_t t);
        nvec++;
        chk("mem_re", idx, 32'(mem_re_o), 32'(t.re));
        chk("mem_addr", idx, 32'(mem_addr_o), 32'(t.addr));
        chk("valid", idx, 32'(instr_valid_o), 32'(t.v));
        chk("count", idx, 32'(count_o), 32'(t.cnt));
        if (t.v) begin
            chk("instr_pc", idx, 32'(instr_pc_o), 32'(t.pc));
            chk("instr", idx, 32'(instr_o), 32'(fdata(t.pc)));
        end
    endtask

    initial begin
        //            rd ra        hd wt rd  re addr       v pc         c
        // fill to full with ready low
        tbl[0]  = mk(0, 24'h0,     0, 0, 0,  1, 24'h00000, 0, 24'h0,     0);
        tbl[1]  = mk(0, 24'h0,     0, 0, 0,  1, 24'h00002, 1, 24'h0,     1);
        tbl[2]  = mk(0, 24'h0,     0, 0, 0,  1, 24'h00004, 1, 24'h0,     2);
        tbl[3]  = mk(0, 24'h0,     0, 0, 0,  1, 24'h00006, 1, 24'h0,     3);
        tbl[4]  = mk(0, 24'h0,     0, 0, 0,  0, 24'h00008, 1, 24'h0,     4);
        tbl[5]  = mk(0, 24'h0,     0, 0, 0,  0, 24'h00008, 1, 24'h0,     4);
        // one pop from full, one refill
        tbl[6]  = mk(0, 24'h0,     0, 0, 1,  0, 24'h00008, 1, 24'h0,     4);
        tbl[7]  = mk(0, 24'h0,     0, 0, 0,  1, 24'h00008, 1, 24'h2,     3);
        tbl[8]  = mk(0, 24'h0,     0, 0, 0,  0, 24'h0000A, 1, 24'h2,     4);
        // streaming: push and pop each cycle
        tbl[9]  = mk(0, 24'h0,     0, 0, 1,  0, 24'h0000A, 1, 24'h2,     4);
        tbl[10] = mk(0, 24'h0,     0, 0, 1,  1, 24'h0000A, 1, 24'h4,     3);
        tbl[11] = mk(0, 24'h0,     0, 0, 1,  1, 24'h0000C, 1, 24'h6,     3);
        tbl[12] = mk(0, 24'h0,     0, 0, 1,  1, 24'h0000E, 1, 24'h8,     3);
        // three wait cycles on 0x10
        tbl[13] = mk(0, 24'h0,     0, 1, 0,  1, 24'h00010, 1, 24'hA,     3);
        tbl[14] = mk(0, 24'h0,     0, 1, 0,  1, 24'h00010, 1, 24'hA,     3);
        tbl[15] = mk(0, 24'h0,     0, 1, 0,  1, 24'h00010, 1, 24'hA,     3);
        tbl[16] = mk(0, 24'h0,     0, 0, 0,  1, 24'h00010, 1, 24'hA,     3);
        tbl[17] = mk(0, 24'h0,     0, 0, 0,  0, 24'h00012, 1, 24'hA,     4);
        // hold with pops draining the queue
        tbl[18] = mk(0, 24'h0,     1, 0, 1,  0, 24'h00012, 1, 24'hA,     4);
        tbl[19] = mk(0, 24'h0,     1, 0, 1,  0, 24'h00012, 1, 24'hC,     3);
        tbl[20] = mk(0, 24'h0,     1, 0, 1,  0, 24'h00012, 1, 24'hE,     2);
        tbl[21] = mk(0, 24'h0,     1, 0, 1,  0, 24'h00012, 1, 24'h10,    1);
        tbl[22] = mk(0, 24'h0,     1, 0, 1,  0, 24'h00012, 0, 24'h0,     0);
        tbl[23] = mk(0, 24'h0,     1, 0, 1,  0, 24'h00012, 0, 24'h0,     0);
        tbl[24] = mk(0, 24'h0,     1, 0, 1,  0, 24'h00012, 0, 24'h0,     0);
        tbl[25] = mk(0, 24'h0,     0, 0, 1,  1, 24'h00012, 0, 24'h0,     0);
        tbl[26] = mk(0, 24'h0,     0, 0, 1,  1, 24'h00014, 1, 24'h12,    1);
        tbl[27] = mk(0, 24'h0,     0, 0, 0,  1, 24'h00016, 1, 24'h14,    1);
        // redirect with pop pending, bank wrap afterwards
        tbl[28] = mk(1, 24'h05FFFE, 0, 0, 1, 0, 24'h00018, 1, 24'h14,    2);
        tbl[29] = mk(0, 24'h0,     0, 0, 1,  1, 24'h05FFFE, 0, 24'h0,    0);
        tbl[30] = mk(0, 24'h0,     0, 0, 0,  1, 24'h050000, 1, 24'h05FFFE, 1);
        tbl[31] = mk(0, 24'h0,     0, 0, 0,  1, 24'h050002, 1, 24'h05FFFE, 2);
        // odd redirect target
        tbl[32] = mk(1, 24'h000123, 0, 0, 0, 0, 24'h050004, 1, 24'h05FFFE, 3);
        tbl[33] = mk(0, 24'h0,     0, 0, 1,  1, 24'h000122, 0, 24'h0,    0);
        tbl[34] = mk(0, 24'h0,     0, 0, 1,  1, 24'h000124, 1, 24'h000122, 1);
        tbl[35] = mk(0, 24'h0,     0, 0, 1,  1, 24'h000126, 1, 24'h000124, 1);

        rst_n = 1'b0;
        redirect_i = 1'b0;
        redirect_addr_i = '0;
        hold_i = 1'b0;
        mem_wait_i = 1'b0;
        instr_ready_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        nvec++;
        chk("rst_re", -1, 32'(mem_re_o), 32'h0);
        chk("rst_valid", -1, 32'(instr_valid_o), 32'h0);
        chk("rst_count", -1, 32'(count_o), 32'h0);
        chk("rst_addr", -1, 32'(mem_addr_o), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 36; i++) begin
            redirect_i      = tbl[i].rd;
            redirect_addr_i = tbl[i].ra;
            hold_i          = tbl[i].hold;
            mem_wait_i      = tbl[i].wt;
            instr_ready_i   = tbl[i].rdy;
            #3;
            chk_vec(i, tbl[i]);
            @(posedge clk);
            #1;
        end

        // Reset asserted while a read is stalled mid-transfer.
        redirect_i    = 1'b0;
        hold_i        = 1'b0;
        instr_ready_i = 1'b0;
        mem_wait_i    = 1'b1;
        #2;
        nvec++;
        chk("mid_re", 100, 32'(mem_re_o), 32'h1);
        chk("mid_addr", 100, 32'(mem_addr_o), 32'h000128);
        rst_n = 1'b0;
        #1;
        nvec++;
        chk("arst_re", 101, 32'(mem_re_o), 32'h0);
        chk("arst_valid", 101, 32'(instr_valid_o), 32'h0);
        chk("arst_count", 101, 32'(count_o), 32'h0);
        chk("arst_addr", 101, 32'(mem_addr_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_wait_i = 1'b0;
        #3;
        nvec++;
        chk("rel_re", 102, 32'(mem_re_o), 32'h1);
        chk("rel_addr", 102, 32'(mem_addr_o), 32'h0);
        chk("rel_valid", 102, 32'(instr_valid_o), 32'h0);
        @(posedge clk);
        #1;
        nvec++;
        chk("rel_count", 103, 32'(count_o), 32'h1);
        chk("rel_pc", 103, 32'(instr_pc_o), 32'h0);
        chk("rel_instr", 103, 32'(instr_o), 32'(fdata(24'h0)));
        chk("rel_addr2", 103, 32'(mem_addr_o), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
